// File: rtl/invaders_input_pkg.sv
// Shared scan codes, control bit positions and coin FSM states
// for the invaders input front-end.
package invaders_input_pkg;

  localparam logic [8:0] KC_UP         = 9'h075;
  localparam logic [8:0] KC_DOWN       = 9'h072;
  localparam logic [8:0] KC_LEFT       = 9'h06B;
  localparam logic [8:0] KC_RIGHT      = 9'h074;
  localparam logic [8:0] KC_FIREA      = 9'h014;
  localparam logic [8:0] KC_FIREB      = 9'h011;
  localparam logic [8:0] KC_FIREC      = 9'h029;
  localparam logic [8:0] KC_FIRED      = 9'h012;
  localparam logic [8:0] KC_P2_UP      = 9'h02D;
  localparam logic [8:0] KC_P2_DOWN    = 9'h02B;
  localparam logic [8:0] KC_P2_LEFT    = 9'h023;
  localparam logic [8:0] KC_P2_RIGHT   = 9'h034;
  localparam logic [8:0] KC_P2_FIREA   = 9'h01C;
  localparam logic [8:0] KC_P2_FIREB   = 9'h01B;
  localparam logic [8:0] KC_P2_FIREC   = 9'h021;
  localparam logic [8:0] KC_P2_FIRED   = 9'h01D;
  localparam logic [8:0] KC_START1     = 9'h005;
  localparam logic [8:0] KC_START1_ALT = 9'h016;
  localparam logic [8:0] KC_START2     = 9'h006;
  localparam logic [8:0] KC_START2_ALT = 9'h01E;
  localparam logic [8:0] KC_COIN       = 9'h076;
  localparam logic [8:0] KC_COIN1      = 9'h02E;
  localparam logic [8:0] KC_COIN2      = 9'h036;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_UP    = 3;
  localparam int BIT_FIREA = 4;
  localparam int BIT_FIREB = 5;
  localparam int BIT_FIREC = 6;
  localparam int BIT_FIRED = 7;

  // Held-key vector: one bit per mapped code so aliases release independently
  localparam int K_P1   = 0;
  localparam int K_P2   = 8;
  localparam int K_S1   = 16;
  localparam int K_S2   = 18;
  localparam int K_COIN = 20;
  localparam int NKEYS  = 23;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_REL
  } coin_st_t;

  function automatic logic [NKEYS-1:0] key_sel(
    input logic [8:0] code
  );
    key_sel = '0;
    case (code)
      KC_RIGHT:      key_sel[K_P1+BIT_RIGHT] = 1'b1;
      KC_LEFT:       key_sel[K_P1+BIT_LEFT]  = 1'b1;
      KC_DOWN:       key_sel[K_P1+BIT_DOWN]  = 1'b1;
      KC_UP:         key_sel[K_P1+BIT_UP]    = 1'b1;
      KC_FIREA:      key_sel[K_P1+BIT_FIREA] = 1'b1;
      KC_FIREB:      key_sel[K_P1+BIT_FIREB] = 1'b1;
      KC_FIREC:      key_sel[K_P1+BIT_FIREC] = 1'b1;
      KC_FIRED:      key_sel[K_P1+BIT_FIRED] = 1'b1;
      KC_P2_RIGHT:   key_sel[K_P2+BIT_RIGHT] = 1'b1;
      KC_P2_LEFT:    key_sel[K_P2+BIT_LEFT]  = 1'b1;
      KC_P2_DOWN:    key_sel[K_P2+BIT_DOWN]  = 1'b1;
      KC_P2_UP:      key_sel[K_P2+BIT_UP]    = 1'b1;
      KC_P2_FIREA:   key_sel[K_P2+BIT_FIREA] = 1'b1;
      KC_P2_FIREB:   key_sel[K_P2+BIT_FIREB] = 1'b1;
      KC_P2_FIREC:   key_sel[K_P2+BIT_FIREC] = 1'b1;
      KC_P2_FIRED:   key_sel[K_P2+BIT_FIRED] = 1'b1;
      KC_START1:     key_sel[K_S1]           = 1'b1;
      KC_START1_ALT: key_sel[K_S1+1]         = 1'b1;
      KC_START2:     key_sel[K_S2]           = 1'b1;
      KC_START2_ALT: key_sel[K_S2+1]         = 1'b1;
      KC_COIN:       key_sel[K_COIN]         = 1'b1;
      KC_COIN1:      key_sel[K_COIN+1]       = 1'b1;
      KC_COIN2:      key_sel[K_COIN+2]       = 1'b1;
      default:       key_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/invaders_frame_pulse.sv
// VBlank rising-edge strobe plus an 8-bit frame counter that
// saturates at LIMIT; clr has priority over counting.
module invaders_frame_pulse #(
  parameter int unsigned LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic       clr,
  output logic       tick,
  output logic [7:0] cnt
);

  localparam logic [7:0] MAX = 8'(LIMIT);

  logic vb_q;

  assign tick = vblank & ~vb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q <= 1'b0;
      cnt  <= '0;
    end else begin
      vb_q <= vblank;
      if (clr)
        cnt <= '0;
      else if (tick && cnt != MAX)
        cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/invaders_input_ctrl.sv
// PS/2 + joystick merge, coin pulse shaper and optional fireA
// autofire (enabled by defining INVADERS_AUTOFIRE_EN).
module invaders_input_ctrl
  import invaders_input_pkg::*;
#(
  parameter int unsigned COIN_FRAMES = 4,
  parameter int unsigned AF_FRAMES   = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        VBlank,
  input  logic        autofire,
  output logic [7:0]  p1,
  output logic [7:0]  p2,
  output logic        start1,
  output logic        start2,
  output logic        coin
);

  localparam logic [7:0] COIN_MAX = 8'(COIN_FRAMES);
  localparam logic [7:0] AF_LAST  = 8'(AF_FRAMES - 1);

  logic             tog_q;
  logic             ev;
  logic [NKEYS-1:0] sel;
  logic [NKEYS-1:0] key_st;

  assign ev  = tog_q ^ ps2_key[10];
  assign sel = key_sel(ps2_key[8:0]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tog_q  <= 1'b0;
      key_st <= '0;
    end else begin
      tog_q <= ps2_key[10];
      if (ev)
        key_st <= (key_st & ~sel)
                | (sel & {NKEYS{ps2_key[9]}});
    end
  end

  logic [7:0] p1_raw;
  logic [7:0] p2_raw;
  logic [7:0] p1_nxt;
  logic [7:0] p2_nxt;
  logic       raw;

  assign p1_raw = key_st[K_P1 +: 8] | joy1[7:0];
  assign p2_raw = key_st[K_P2 +: 8] | joy2[7:0];
  assign raw    = |key_st[K_COIN +: 3]
                | joy1[10] | joy2[10];

  coin_st_t   st;
  coin_st_t   st_nxt;
  logic       coin_nxt;
  logic       coin_clr;
  logic       coin_tick;
  logic [7:0] coin_cnt;

  invaders_frame_pulse #(
    .LIMIT(COIN_FRAMES)
  ) u_coin_frames (
    .clk   (Clk),
    .rst_n (Rst_n),
    .vblank(VBlank),
    .clr   (coin_clr),
    .tick  (coin_tick),
    .cnt   (coin_cnt)
  );

  // raw is ignored inside PULSE so blips cannot stretch or restart it
  always_comb begin
    st_nxt   = st;
    coin_nxt = 1'b0;
    coin_clr = 1'b0;
    unique case (st)
      IDLE: begin
        coin_clr = 1'b1;
        if (raw) begin
          st_nxt   = PULSE;
          coin_nxt = 1'b1;
        end
      end
      PULSE: begin
        if (coin_cnt == COIN_MAX)
          st_nxt = raw ? WAIT_REL : IDLE;
        else
          coin_nxt = 1'b1;
      end
      WAIT_REL: begin
        coin_clr = 1'b1;
        if (!raw)
          st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

`ifdef INVADERS_AUTOFIRE_EN
  logic [1:0][7:0] raw_pl;
  logic [1:0]      fire_out;

  assign raw_pl = {p2_raw, p1_raw};

  for (genvar g = 0; g < 2; g++) begin : g_af
    logic       on;
    logic       wrap;
    logic       clr;
    logic       tick;
    logic [7:0] cnt;
    logic       off_q;

    assign on   = autofire & raw_pl[g][BIT_FIREA];
    assign wrap = tick && cnt == AF_LAST;
    assign clr  = ~on | wrap;

    invaders_frame_pulse #(
      .LIMIT(AF_FRAMES)
    ) u_af (
      .clk   (Clk),
      .rst_n (Rst_n),
      .vblank(VBlank),
      .clr   (clr),
      .tick  (tick),
      .cnt   (cnt)
    );

    // off_q=0 means "fire asserted" so every press starts in phase 1
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
        off_q <= 1'b0;
      else if (!on)
        off_q <= 1'b0;
      else if (wrap)
        off_q <= ~off_q;
    end

    assign fire_out[g] = on ? ~off_q
                            : raw_pl[g][BIT_FIREA];
  end

  assign p1_nxt = {p1_raw[7:5], fire_out[0], p1_raw[3:0]};
  assign p2_nxt = {p2_raw[7:5], fire_out[1], p2_raw[3:0]};

  logic unused_sigs;
  assign unused_sigs = ^{joy1[15:11], joy2[15:11],
                         coin_tick};
`else
  assign p1_nxt = p1_raw;
  assign p2_nxt = p2_raw;

  logic unused_sigs;
  assign unused_sigs = ^{joy1[15:11], joy2[15:11],
                         coin_tick, autofire, AF_LAST};
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st     <= IDLE;
      coin   <= 1'b0;
      p1     <= '0;
      p2     <= '0;
      start1 <= 1'b0;
      start2 <= 1'b0;
    end else begin
      st     <= st_nxt;
      coin   <= coin_nxt;
      p1     <= p1_nxt;
      p2     <= p2_nxt;
      start1 <= |key_st[K_S1 +: 2] | joy1[8] | joy2[8];
      start2 <= |key_st[K_S2 +: 2] | joy1[9] | joy2[9];
    end
  end

endmodule
